dac_sample_sequencer: RTL and testbench

Digital front end for the 10-bit charge-scaling DAC macro: buffers 10-bit samples from a bus-side producer, paces them at a programmable sample rate, and drives the DAC's parallel code inputs, enable, and latch pulse. The DAC captures its code on the falling edge of its RST pin. This block guarantees the code is stable before and after that edge. It sits between the peripheral register/stream interface and the DAC macro pins.

---
 rtl/dac_sample_sequencer.sv | 158 +++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: buffers DAC codes in a small FIFO, paces them with a
// prescaler and sequences SETUP/LOAD/HOLD so the code is stable around the
// falling edge of dac_rst_o, where the DAC macro captures it.
module dac_sample_sequencer #(
  parameter int unsigned DW       = 10,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PRESC_W  = 16,
  parameter int unsigned LOAD_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [PRESC_W-1:0]       div_i,
  input  logic [DW-1:0]            in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     clr_underrun_i,
  output logic [DW-1:0]            dac_seld_o,
  output logic                     dac_rst_o,
  output logic                     dac_en_o,
  output logic                     underrun_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, LOAD, HOLD} state_e;

  state_e             state_q, state_d;
  logic [LCW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               en_q;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q;
  logic [DW-1:0]      seld_q, seld_d;
  logic               dac_rst_q;
  logic               busy_q;
  logic               underrun_q;

  logic               tick_c;
  logic               push_c;
  logic               pop_c;
  logic               underrun_set_c;

  // A div lowered below the running count ticks at once instead of wrapping.
  assign tick_c     = en_q && (cnt_q >= div_i);
  assign in_ready_o = (level_q != LW'(DEPTH));
  assign push_c     = in_valid_i && in_ready_o;

  // Prescaler next count: ticks taken while busy hold the count until IDLE.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_q) begin
      cnt_d = '0;
    end else if (tick_c) begin
      if (state_q == IDLE) begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  // Sequencer next state; the only pop and code update happen on IDLE->SETUP.
  always_comb begin
    state_d        = state_q;
    ld_cnt_d       = ld_cnt_q;
    seld_d         = seld_q;
    pop_c          = 1'b0;
    underrun_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          if (level_q != '0) begin
            pop_c   = 1'b1;
            seld_d  = mem_q[rd_ptr_q];
            state_d = SETUP;
          end else begin
            underrun_set_c = 1'b1;
          end
        end
      end
      SETUP: begin
        ld_cnt_d = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        if (ld_cnt_q == LCW'(LOAD_CYC - 1)) begin
          state_d = HOLD;
        end else begin
          ld_cnt_d = ld_cnt_q + LCW'(1);
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, prescaler, FIFO pointers and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seld_q     <= '0;
      dac_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      cnt_q      <= cnt_d;
      en_q       <= en_i;
      seld_q     <= seld_d;
      dac_rst_q  <= (state_d == LOAD);
      busy_q     <= (state_d != IDLE);
      underrun_q <= underrun_set_c || (underrun_q && !clr_underrun_i);
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  assign dac_seld_o = seld_q;
  assign dac_rst_o  = dac_rst_q;
  assign dac_en_o   = en_q;
  assign underrun_o = underrun_q;
  assign level_o    = level_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Bench for dac_sample_sequencer: a tick-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dac_sample_sequencer;

  localparam int DEPTH = 4;
  localparam int LC    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clr;
  logic [9:0]  dac_seld;
  logic        dac_rst;
  logic        dac_en;
  logic        underrun;
  logic [2:0]  level;
  logic        busy;

  int total = 0;
  int bad   = 0;

  dac_sample_sequencer #(
    .DW(10), .DEPTH(DEPTH), .PRESC_W(16), .LOAD_CYC(LC)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .div_i(div),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .clr_underrun_i(clr), .dac_seld_o(dac_seld), .dac_rst_o(dac_rst),
    .dac_en_o(dac_en), .underrun_o(underrun), .level_o(level), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: timeline of the last accepted tick plus a sample queue.
  int          mcyc = 0;
  int          m_t = -1000;
  int          m_cnt = 0;
  bit          m_enq = 0;
  bit          m_und = 0;
  logic [9:0]  m_seld = '0;
  logic [9:0]  m_q[$];
  bit          m_idle, m_tick, m_set, m_room;

  function automatic bit m_busy(input int c);
    return (c >= m_t + 1) && (c <= m_t + 2 + LC);
  endfunction

  function automatic bit m_pulse(input int c);
    return (c >= m_t + 2) && (c <= m_t + 1 + LC);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_t = -1000; m_cnt = 0; m_enq = 0; m_und = 0; m_seld = '0;
      m_q.delete();
    end else begin
      m_idle = !m_busy(mcyc);
      m_tick = m_enq && (m_cnt == int'(div));
      m_room = m_q.size() < DEPTH;
      m_set  = 0;
      if (m_tick && m_idle) begin
        if (m_q.size() > 0) begin
          m_seld = m_q.pop_front();
          m_t    = mcyc;
        end else begin
          m_set = 1;
        end
      end
      m_und = m_set || (m_und && !clr);
      if (!m_enq) m_cnt = 0;
      else if (m_cnt == int'(div)) begin
        if (m_idle) m_cnt = 0;
      end else m_cnt++;
      if (in_valid && m_room) m_q.push_back(in_data);
      m_enq = en;
    end
    mcyc++;
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("seld",     int'(dac_seld), int'(m_seld));
      check("dac_rst",  int'(dac_rst),  int'(m_pulse(mcyc)));
      check("busy",     int'(busy),     int'(m_busy(mcyc)));
      check("level",    int'(level),    m_q.size());
      check("in_ready", int'(in_ready), int'(m_q.size() < DEPTH));
      check("dac_en",   int'(dac_en),   int'(m_enq));
      check("underrun", int'(underrun), int'(m_und));
    end
  end

  task automatic push(input logic [9:0] d);
    in_data = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; in_valid = 1'b0; clr = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rise(input int budget, output int t);
    int k;
    k = 0;
    while (dac_rst !== 1'b1 && k < budget) begin
      @(negedge clk); k++;
    end
    if (dac_rst !== 1'b1) begin
      total++; bad++;
      $display("FAIL rise_timeout: no dac_rst pulse within %0d cycles at t=%0t", budget, $time);
    end
    t = mcyc;
  endtask

  task automatic pulse_width(input int budget, output int w);
    w = 0;
    while (dac_rst === 1'b1 && w < budget) begin
      w++; @(negedge clk);
    end
  endtask

  logic [9:0] vals [5];
  int t, tp, w, k, highs;

  initial begin
    rst = 1'b1; en = 1'b0; div = '0; in_data = '0; in_valid = 1'b0; clr = 1'b0;
    vals[0] = 10'h3FF; vals[1] = 10'h001; vals[2] = 10'h200; vals[3] = 10'h0AB; vals[4] = 10'h111;
    repeat (2) @(negedge clk);
    check("rst_level", int'(level), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_seld", int'(dac_seld), 0);
    check("rst_busy", int'(busy), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Basic pacing
    div = 16'd9;
    push(10'h155); push(10'h2AA);
    en = 1'b1;
    wait_rise(40, t);  check("p1_code", int'(dac_seld), 'h155);
    pulse_width(10, w); check("p1_width", w, 2);
    wait_rise(40, tp); check("p2_code", int'(dac_seld), 'h2AA);
    check("p_gap", tp - t, 10);
    pulse_width(10, w); check("p2_width", w, 2);

    // Full FIFO
    do_reset();
    div = 16'd9;
    for (int i = 0; i < 5; i++) begin
      push(vals[i]);
      if (i == 3) begin
        check("full_level", int'(level), 4);
        check("full_ready", int'(in_ready), 0);
      end
    end
    check("full_level5", int'(level), 4);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rise(40, t);
      check("full_code", int'(dac_seld), int'(vals[i]));
      pulse_width(10, w);
    end
    repeat (25) @(negedge clk);
    check("full_drained", int'(level), 0);
    check("full_underrun", int'(underrun), 1);

    // Underrun and clear priority
    do_reset();
    div = 16'd5;
    push(10'h0F0);
    en = 1'b1;
    wait_rise(30, t); check("u_code", int'(dac_seld), 'h0F0);
    pulse_width(10, w);
    k = 0;
    while (underrun !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    check("u_set", int'(underrun), 1);
    check("u_hold_code", int'(dac_seld), 'h0F0);
    repeat (5) @(negedge clk);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("u_set_prio", int'(underrun), 1);
    @(negedge clk);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("u_cleared", int'(underrun), 0);

    // Tick deferral: back-to-back every LC+3 cycles
    do_reset();
    div = 16'd1;
    for (int i = 0; i < 4; i++) push(vals[i]);
    en = 1'b1;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rise(20, t);
      check("d_code", int'(dac_seld), int'(vals[i]));
      if (i > 0) check("d_gap", t - tp, LC + 3);
      tp = t;
      pulse_width(10, w);
    end

    // Enable drop during LOAD
    do_reset();
    div = 16'd9;
    push(10'h101); push(10'h202); push(10'h303);
    en = 1'b1;
    wait_rise(30, t);
    en = 1'b0;
    @(negedge clk);
    check("e_dac_en", int'(dac_en), 0);
    check("e_still_load", int'(dac_rst), 1);
    pulse_width(10, w); check("e_rest_width", w, 1);
    check("e_code", int'(dac_seld), 'h101);
    highs = 0;
    repeat (30) begin
      @(negedge clk);
      if (dac_rst === 1'b1) highs++;
    end
    check("e_no_loads", highs, 0);
    check("e_level", int'(level), 2);

    // Async reset in the middle of LOAD
    en = 1'b1;
    wait_rise(30, t);
    #2 rst = 1'b1;
    #1;
    check("r_dac_rst", int'(dac_rst), 0);
    check("r_seld", int'(dac_seld), 0);
    check("r_busy", int'(busy), 0);
    check("r_level", int'(level), 0);
    check("r_ready", int'(in_ready), 1);
    check("r_dac_en", int'(dac_en), 0);
    en = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
